// File: rtl/mem_model_pkg.sv
// Shared types for the pipelined memory model: FSM states, response payload
// and a parameter sanity helper.
package mem_model_pkg;

  // Widest word the response payload can carry; narrower words are zero-extended.
  localparam int unsigned MAX_DATA_WIDTH = 64;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] rdata;
    logic                      error;
  } rsp_t;

  function automatic bit legal_read_latency(int unsigned lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Stall-able response shift pipeline; all stages move together on advance.
module mem_rsp_pipe
  import mem_model_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  rsp_t in_rsp,
  input  logic out_ready,
  output logic out_valid,
  output rsp_t out_rsp,
  output logic advance
);

  logic [READ_LATENCY-1:0] valid_q;
  rsp_t                    rsp_q [READ_LATENCY];

  assign out_valid = valid_q[READ_LATENCY-1];
  assign out_rsp   = rsp_q[READ_LATENCY-1];
  assign advance   = !(out_valid && !out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        rsp_q[i] <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      // Empty slots carry zeros so idle outputs read back as 0.
      rsp_q[0]   <= in_valid ? in_rsp : '0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        valid_q[i] <= valid_q[i-1];
        rsp_q[i]   <= rsp_q[i-1];
      end
    end
  end

endmodule

// File: rtl/pipelined_memory_model.sv
// Single-port memory with valid/ready request/response, byte-enable writes,
// configurable read latency, range errors and a self-initialisation sequencer.
module pipelined_memory_model
  import mem_model_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 2**ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [7:0]  INIT_BYTE    = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic                    clear,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    init_busy
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  if (!legal_read_latency(READ_LATENCY) || (DATA_WIDTH % 8 != 0) ||
      (DATA_WIDTH > MAX_DATA_WIDTH) || (DEPTH < 1) || (DEPTH > 2**ADDR_WIDTH)) begin : g_bad_params
    $error("pipelined_memory_model: illegal parameter combination");
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    advance, accept, in_range, init_last;
  rsp_t                    rsp_in, rsp_out;
  logic                    unused_rsp_rdata;

  assign in_range  = {1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH);
  assign init_last = init_cnt_q == ADDR_WIDTH'(DEPTH - 1);
  assign init_busy = state_q == ST_INIT;
  assign req_ready = (state_q == ST_RUN) && advance;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_last) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Array is deliberately not reset; contents become defined through ST_INIT.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[init_cnt_q] <= {NUM_BYTES{INIT_BYTE}};
    end else if (accept && req_write && in_range) begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
        if (req_wstrb[b]) begin
          mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rsp_in       = '0;
    rsp_in.error = !in_range;
    if (!req_write && in_range) begin
      rsp_in.rdata = MAX_DATA_WIDTH'(mem[req_addr]);
    end
  end

  mem_rsp_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rsp_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (accept),
    .in_rsp   (rsp_in),
    .out_ready(rsp_ready),
    .out_valid(rsp_valid),
    .out_rsp  (rsp_out),
    .advance  (advance)
  );

  assign rsp_rdata        = rsp_out.rdata[DATA_WIDTH-1:0];
  assign rsp_error        = rsp_out.error;
  assign unused_rsp_rdata = ^rsp_out.rdata;

endmodule

// File: tb/tb_pipelined_memory_model.sv
// Randomised and directed bench for pipelined_memory_model against a
// word-array/response-queue reference model.
module tb_pipelined_memory_model;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned RL    = 3;
  localparam logic [31:0] INIT_WORD = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write, clear;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_wstrb;
  logic [DW-1:0] req_wdata, rsp_rdata;
  logic          rsp_valid, rsp_ready, rsp_error, init_busy;

  pipelined_memory_model #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .READ_LATENCY(RL),
    .INIT_BYTE   (8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wstrb(req_wstrb),
    .req_wdata(req_wdata),
    .clear    (clear),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_mem [DEPTH];
  logic [32:0] exp_q [$];
  int          init_left;
  logic        prev_stall;
  logic [31:0] prev_rdata, last_rdata;
  logic        prev_error, last_error;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_init();
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = INIT_WORD;
    init_left = DEPTH;
  endtask

  // One clock cycle: drive at negedge, check just after, update model for the next posedge.
  task automatic do_cycle(input logic v, input logic w, input logic [3:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic rr, input logic clr,
                          output logic acc, output logic got);
    logic [32:0] e;
    logic        exp_ready;
    @(negedge clk);
    req_valid = v; req_write = w; req_addr = a; req_wstrb = s; req_wdata = d;
    rsp_ready = rr; clear = clr;
    #1;
    if (prev_stall) begin
      check_val("stall_valid", 64'(rsp_valid), 64'd1);
      check_val("stall_rdata", 64'(rsp_rdata), 64'(prev_rdata));
      check_val("stall_error", 64'(rsp_error), 64'(prev_error));
    end
    check_val("init_busy", 64'(init_busy), 64'(init_left != 0));
    exp_ready = (init_left == 0) && !(rsp_valid && !rr);
    check_val("req_ready", 64'(req_ready), 64'(exp_ready));
    got = rsp_valid && rr;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_rsp", 64'(rsp_valid), 64'd0);
      end else if (rr) begin
        e = exp_q.pop_front();
        check_val("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        check_val("rsp_error", 64'(rsp_error), 64'(e[32]));
        last_rdata = rsp_rdata;
        last_error = rsp_error;
      end
    end
    prev_stall = rsp_valid && !rr;
    prev_rdata = rsp_rdata;
    prev_error = rsp_error;
    acc = v && req_ready;
    if (acc) begin
      if (a >= DEPTH) begin
        exp_q.push_back({1'b1, 32'h0});
      end else if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
        exp_q.push_back({1'b0, 32'h0});
      end else begin
        exp_q.push_back({1'b0, model_mem[a]});
      end
    end
    if (init_left != 0) init_left--;
    else if (clr) model_init();
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
    logic acc, got;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) do_cycle(1'b1, w, a, s, d, 1'b1, 1'b0, acc, got);
    check_val("issue_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    logic acc, got;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || init_left != 0); i++)
      do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 1'b0, acc, got);
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic count_init();
    logic acc, got;
    int   n_busy;
    n_busy = 0;
    for (int i = 0; i < 4 * int'(DEPTH); i++) begin
      do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 1'b0, acc, got);
      if (init_busy) n_busy++;
      else break;
    end
    check_val("init_cycles", 64'(n_busy), 64'(DEPTH));
  endtask

  initial begin
    logic acc, got;
    int   sent, got_n, stall_left, n;
    logic first_seen, rr;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wstrb = '0;
    req_wdata = '0; clear = 1'b0; rsp_ready = 1'b1; prev_stall = 1'b0;
    last_rdata = '0; last_error = 1'b0;
    #1;
    check_val("rst_req_ready", 64'(req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check_val("rst_rsp_error", 64'(rsp_error), 64'd0);
    check_val("rst_init_busy", 64'(init_busy), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_init();
    count_init();

    for (int a = 0; a < int'(DEPTH); a++) issue(1'b0, 4'(a), 4'd0, 32'd0);
    drain();

    issue(1'b1, 4'd3, 4'b0101, 32'hAABB_CCDD);
    issue(1'b0, 4'd3, 4'd0, 32'd0);
    drain();
    check_val("strobe_rdata", 64'(last_rdata), 64'hFFBB_FFDD);

    // Back-to-back reads 0..5 with rsp_ready held low for 4 cycles at the first response.
    sent = 0; got_n = 0; stall_left = 4; first_seen = 1'b0;
    for (int c = 0; c < 60 && got_n < 6; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) first_seen = 1'b1;
      rr = !(first_seen && stall_left > 0);
      if (!rr) stall_left--;
      do_cycle(sent < 6, 1'b0, 4'(sent), 4'd0, 32'd0, rr, 1'b0, acc, got);
      if (acc) sent++;
      if (got) got_n++;
    end
    check_val("stall_rsp_count", 64'(got_n), 64'd6);
    drain();

    issue(1'b1, 4'd13, 4'hF, 32'h55);
    drain();
    check_val("oor_write_error", 64'(last_error), 64'd1);
    issue(1'b0, 4'd13, 4'd0, 32'd0);
    drain();
    check_val("oor_read_error", 64'(last_error), 64'd1);
    check_val("oor_read_rdata", 64'(last_rdata), 64'd0);
    issue(1'b0, 4'd11, 4'd0, 32'd0);
    drain();
    check_val("last_word_error", 64'(last_error), 64'd0);
    check_val("last_word_rdata", 64'(last_rdata), 64'(INIT_WORD));

    issue(1'b1, 4'd2, 4'hF, 32'h12);
    do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 1'b1, acc, got);
    drain();
    issue(1'b0, 4'd2, 4'd0, 32'd0);
    drain();
    check_val("clear_rdata", 64'(last_rdata), 64'(INIT_WORD));

    issue(1'b0, 4'd0, 4'd0, 32'd0);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 1'b0, acc, got);
      if (got) begin n = i; break; end
    end
    check_val("read_latency", 64'(n), 64'(RL));
    drain();

    for (int c = 0; c < 400; c++)
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               4'($urandom), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
               acc, got);
    drain();

    // Reset with two reads in flight, one already presented at the output.
    do_cycle(1'b1, 1'b0, 4'd1, 4'd0, 32'd0, 1'b1, 1'b0, acc, got);
    do_cycle(1'b1, 1'b0, 4'd2, 4'd0, 32'd0, 1'b1, 1'b0, acc, got);
    do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, acc, got);
    @(posedge clk); #1;
    check_val("pre_reset_valid", 64'(rsp_valid), 64'd1);
    reset = 1'b1;
    #1;
    check_val("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("reset_init_busy", 64'(init_busy), 64'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    model_init();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    count_init();
    issue(1'b0, 4'd1, 4'd0, 32'd0);
    drain();
    check_val("post_reset_rdata", 64'(last_rdata), 64'(INIT_WORD));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
